// File: rtl/rstack_pkg.sv
// Shared CPU package: default instruction-pointer width, default return-stack
// depth and the stack-op encoding shared by next-IP logic, the return stack
// and the data stack.
package rstack_pkg;

    localparam int DEFAULT_IADDR_WIDTH = 10;
    localparam int DEFAULT_DEPTH       = 16;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_t;

    // Collapse the push/pop strobes into a single stack operation.
    function automatic stack_op_t decode_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_REPLACE;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rstack_if.sv
// Return-stack bus: call/return strobes, return address, error clear and the
// registered stack status seen by the next-IP logic.
interface rstack_if
    import rstack_pkg::*;
#(
    parameter int iaddr_width = DEFAULT_IADDR_WIDTH,
    parameter int depth       = DEFAULT_DEPTH
);
    logic                     push;
    logic                     pop;
    logic [iaddr_width-1:0]   push_data;
    logic                     err_clr;
    logic [iaddr_width-1:0]   rstack_top;
    logic [$clog2(depth):0]   level;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output push, pop, push_data, err_clr,
        input  rstack_top, level, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, err_clr,
        output rstack_top, level, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_ram.sv
// stack_ram: entry storage for the return and data stacks. One synchronous
// write port, one asynchronous read port, no reset on the contents.
module stack_ram #(
    parameter int width      = 10,
    parameter int entries    = 15,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [addr_width-1:0] i_waddr,
    input  logic [width-1:0]      i_wdata,
    input  logic [addr_width-1:0] i_raddr,
    output logic [width-1:0]      o_rdata
);
    logic [width-1:0] r_mem [0:entries-1];

    // Single write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rstack.sv
// rstack: return-address stack. The top entry lives in its own register so
// rstack_top has no read latency; deeper entries sit in stack_ram addressed
// by level-2. Define RSTACK_ERR_EN to get sticky overflow/underflow flags
// cleared by err_clr; otherwise those outputs are tied low.
module rstack
    import rstack_pkg::*;
#(
    parameter int iaddr_width = DEFAULT_IADDR_WIDTH,
    parameter int depth       = DEFAULT_DEPTH
) (
    input logic     clk,
    input logic     reset,
    rstack_if.slave bus
);
    localparam int LW = $clog2(depth) + 1;
    localparam int AW = $clog2(depth);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(depth);

    logic [iaddr_width-1:0] r_top;
    logic [iaddr_width-1:0] w_top_next;
    logic [iaddr_width-1:0] w_rdata;
    logic [LW-1:0]          r_level;
    logic [LW-1:0]          w_level_next;
    logic [AW-1:0]          w_waddr;
    logic [AW-1:0]          w_raddr;
    logic                   w_we;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_ovf_set;
    logic                   w_unf_set;
    stack_op_t              w_op;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LEVEL_FULL);
    assign w_op    = decode_op(bus.push, bus.pop);

    // The outgoing top lands just above the current array top; the entry
    // that becomes the new top on a pop sits at level-2.
    assign w_waddr = AW'(r_level - LW'(1));
    assign w_raddr = (r_level >= LW'(2)) ? AW'(r_level - LW'(2)) : '0;

    stack_ram #(
        .width      (iaddr_width),
        .entries    (depth - 1),
        .addr_width (AW)
    ) u_stack_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (r_top),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Next top/level, array write enable and error-set conditions per operation.
    always_comb begin
        w_top_next   = r_top;
        w_level_next = r_level;
        w_we         = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        unique case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_top_next   = bus.push_data;
                    w_level_next = r_level + LW'(1);
                    w_we         = !w_empty;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_level_next = r_level - LW'(1);
                    w_top_next   = (r_level == LW'(1)) ? '0 : w_rdata;
                end
            end
            OP_REPLACE: begin
                // On an empty stack there is nothing to replace: act as a push.
                if (w_empty) begin
                    w_unf_set    = 1'b1;
                    w_top_next   = bus.push_data;
                    w_level_next = LW'(1);
                end else begin
                    w_top_next = bus.push_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Top register and entry count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_level <= '0;
        end else begin
            r_top   <= w_top_next;
            r_level <= w_level_next;
        end
    end

    assign bus.rstack_top = r_top;
    assign bus.level      = r_level;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;

`ifdef RSTACK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set)        r_overflow  <= 1'b1;
            else if (bus.err_clr) r_overflow  <= 1'b0;
            if (w_unf_set)        r_underflow <= 1'b1;
            else if (bus.err_clr) r_underflow <= 1'b0;
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    logic [2:0] w_flags_unused;
    assign w_flags_unused = {bus.err_clr, w_ovf_set, w_unf_set};
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_rstack.sv
// tb_rstack: directed and random checks of rstack (depth 4, 10-bit addresses)
// against a queue-based model of a bounded LIFO with sticky error flags.
module tb_rstack;
    import rstack_pkg::*;

    localparam int IW    = 10;
    localparam int DEPTH = 4;
`ifdef RSTACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rstack_if #(.iaddr_width(IW), .depth(DEPTH)) bus ();

    rstack #(.iaddr_width(IW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned m_q[$];
    bit          m_ovf;
    bit          m_unf;
    int          n_vec;
    int          n_err;

    function automatic int unsigned m_top();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : 0;
    endfunction

    function automatic int unsigned m_level();
        return m_q.size();
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, return at the
    // following falling edge with inputs idle.
    task automatic step(input bit p, input bit o, input int unsigned d, input bit clr);
        bit set_o;
        bit set_u;
        int unsigned dm;
        set_o = 1'b0;
        set_u = 1'b0;
        dm    = d & 32'h3FF;
        bus.push      = p;
        bus.pop       = o;
        bus.push_data = dm[IW-1:0];
        bus.err_clr   = clr;
        @(posedge clk);
        if (p && o) begin
            if (m_q.size() == 0) begin
                set_u = 1'b1;
                m_q.push_back(dm);
            end else begin
                m_q[m_q.size()-1] = dm;
            end
        end else if (p) begin
            if (m_q.size() == DEPTH) set_o = 1'b1;
            else m_q.push_back(dm);
        end else if (o) begin
            if (m_q.size() == 0) set_u = 1'b1;
            else void'(m_q.pop_back());
        end
        if (ERR_EN) begin
            m_ovf = set_o | (m_ovf & ~clr);
            m_unf = set_u | (m_unf & ~clr);
        end
        @(negedge clk);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (bus.level !== 3'd0)    begin n_err++; $display("FAIL reset_level got %0d expected 0", bus.level); end
        n_vec++; if (bus.rstack_top !== 10'h000) begin n_err++; $display("FAIL reset_top got %0h expected 0", bus.rstack_top); end
        n_vec++; if (bus.empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty got %0b expected 1", bus.empty); end
        n_vec++; if (bus.full !== 1'b0)     begin n_err++; $display("FAIL reset_full got %0b expected 0", bus.full); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b expected 0", bus.overflow); end
        n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_unf got %0b expected 0", bus.underflow); end
        $display("reset: level=%0d top=%0h empty=%0b", bus.level, bus.rstack_top, bus.empty);
    endtask

    task automatic test_push();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0, i, 1'b0);
            n_vec++; if (bus.rstack_top !== IW'(i)) begin n_err++; $display("FAIL push_top got %0h expected %0h", bus.rstack_top, i); end
            n_vec++; if (bus.level !== 3'(i)) begin n_err++; $display("FAIL push_level got %0d expected %0d", bus.level, i); end
            $display("push %0h: top=%0h level=%0d", i, bus.rstack_top, bus.level);
        end
    endtask

    task automatic test_pop();
        for (int i = 2; i >= 0; i--) begin
            step(1'b0, 1'b1, 0, 1'b0);
            n_vec++; if (bus.rstack_top !== IW'(i)) begin n_err++; $display("FAIL pop_top got %0h expected %0h", bus.rstack_top, i); end
            n_vec++; if (bus.level !== 3'(i)) begin n_err++; $display("FAIL pop_level got %0d expected %0d", bus.level, i); end
            $display("pop: top=%0h level=%0d", bus.rstack_top, bus.level);
        end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL pop_empty got %0b expected 1", bus.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h10 + i, 1'b0);
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full got %0b expected 1", bus.full); end
        step(1'b1, 1'b0, 32'h3FF, 1'b0);
        n_vec++; if (bus.rstack_top !== 10'h013) begin n_err++; $display("FAIL ovf_top got %0h expected 13", bus.rstack_top); end
        n_vec++; if (bus.level !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d expected 4", bus.level); end
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %0b expected 1", bus.full); end
        n_vec++; if (bus.overflow !== ERR_EN) begin n_err++; $display("FAIL ovf_flag got %0b expected %0b", bus.overflow, ERR_EN); end
        $display("overflow push 3ff: top=%0h level=%0d ovf=%0b", bus.rstack_top, bus.level, bus.overflow);
        step(1'b0, 1'b0, 0, 1'b1);
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %0b expected 0", bus.overflow); end
        for (int i = 2; i >= -1; i--) begin
            step(1'b0, 1'b1, 0, 1'b0);
            n_vec++; if (bus.rstack_top !== ((i >= 0) ? IW'(32'h10 + i) : 10'h000)) begin n_err++; $display("FAIL drain_top got %0h expected %0h", bus.rstack_top, (i >= 0) ? 32'h10 + i : 0); end
        end
        $display("drain: level=%0d empty=%0b", bus.level, bus.empty);
    endtask

    task automatic test_replace();
        step(1'b1, 1'b0, 32'h044, 1'b0);
        step(1'b1, 1'b0, 32'h055, 1'b0);
        step(1'b1, 1'b1, 32'h2AA, 1'b0);
        n_vec++; if (bus.rstack_top !== 10'h2AA) begin n_err++; $display("FAIL repl_top got %0h expected 2aa", bus.rstack_top); end
        n_vec++; if (bus.level !== 3'd2) begin n_err++; $display("FAIL repl_level got %0d expected 2", bus.level); end
        step(1'b0, 1'b1, 0, 1'b0);
        n_vec++; if (bus.rstack_top !== 10'h044) begin n_err++; $display("FAIL repl_pop got %0h expected 44", bus.rstack_top); end
        $display("replace 2aa then pop: top=%0h level=%0d", bus.rstack_top, bus.level);
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1'b1, 32'h0AB, 1'b0);
        n_vec++; if (bus.rstack_top !== 10'h0AB) begin n_err++; $display("FAIL repl_empty_top got %0h expected ab", bus.rstack_top); end
        n_vec++; if (bus.level !== 3'd1) begin n_err++; $display("FAIL repl_empty_level got %0d expected 1", bus.level); end
        n_vec++; if (bus.underflow !== ERR_EN) begin n_err++; $display("FAIL repl_empty_unf got %0b expected %0b", bus.underflow, ERR_EN); end
        $display("replace on empty: top=%0h level=%0d unf=%0b", bus.rstack_top, bus.level, bus.underflow);
        step(1'b0, 1'b1, 0, 1'b1);
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 0, 1'b0);
        n_vec++; if (bus.underflow !== ERR_EN) begin n_err++; $display("FAIL unf_flag got %0b expected %0b", bus.underflow, ERR_EN); end
        n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL unf_level got %0d expected 0", bus.level); end
        n_vec++; if (bus.rstack_top !== 10'h000) begin n_err++; $display("FAIL unf_top got %0h expected 0", bus.rstack_top); end
        step(1'b0, 1'b0, 0, 1'b1);
        n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL unf_clr got %0b expected 0", bus.underflow); end
        step(1'b0, 1'b1, 0, 1'b1);
        n_vec++; if (bus.underflow !== ERR_EN) begin n_err++; $display("FAIL unf_set_wins got %0b expected %0b", bus.underflow, ERR_EN); end
        $display("underflow: unf=%0b level=%0d", bus.underflow, bus.level);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0A0 + i, 1'b0);
        #2 reset = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        n_vec++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL areset_level got %0d expected 0", bus.level); end
        n_vec++; if (bus.rstack_top !== 10'h000) begin n_err++; $display("FAIL areset_top got %0h expected 0", bus.rstack_top); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL areset_empty got %0b expected 1", bus.empty); end
        n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL areset_unf got %0b expected 0", bus.underflow); end
        $display("async reset: level=%0d top=%0h", bus.level, bus.rstack_top);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 32'h123, 1'b0);
        n_vec++; if (bus.rstack_top !== 10'h123) begin n_err++; $display("FAIL areset_push got %0h expected 123", bus.rstack_top); end
        $display("push after reset: top=%0h", bus.rstack_top);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            bit p, o, c;
            r = $urandom_range(0, 99);
            p = (r < 45) || (r >= 85);
            o = (r >= 40) && (r < 95);
            c = ($urandom_range(0, 9) == 0);
            step(p, o, $urandom_range(0, 1023), c);
            n_vec++; if (bus.rstack_top !== IW'(m_top())) begin n_err++; $display("FAIL rnd_top got %0h expected %0h", bus.rstack_top, m_top()); end
            n_vec++; if (bus.level !== 3'(m_level())) begin n_err++; $display("FAIL rnd_level got %0d expected %0d", bus.level, m_level()); end
            n_vec++; if (bus.empty !== (m_level() == 0)) begin n_err++; $display("FAIL rnd_empty got %0b expected %0b", bus.empty, m_level() == 0); end
            n_vec++; if (bus.full !== (m_level() == DEPTH)) begin n_err++; $display("FAIL rnd_full got %0b expected %0b", bus.full, m_level() == DEPTH); end
            n_vec++; if (bus.overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf got %0b expected %0b", bus.overflow, m_ovf); end
            n_vec++; if (bus.underflow !== m_unf) begin n_err++; $display("FAIL rnd_unf got %0b expected %0b", bus.underflow, m_unf); end
            $display("rnd %0d push=%0b pop=%0b clr=%0b top=%0h level=%0d", n, p, o, c, bus.rstack_top, bus.level);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        m_ovf         = 1'b0;
        m_unf         = 1'b0;
        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;
        bus.err_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_push();
        test_pop();
        test_overflow();
        test_replace();
        test_underflow();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
